// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-FU one-entry holders, up to CDB_WIDTH rotating-priority grants per cycle.
// Define CDB_ARB_AGE_EN to add per-holder wait counters that promote starved entries.
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  tag;
    logic [31:0] value;
  } EX_PACKET;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_FU       = 6,
  parameter int unsigned CDB_WIDTH    = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  EX_PACKET          fu_packet_in  [NUM_FU],
  output logic [NUM_FU-1:0] fu_stall_out,
  output EX_PACKET          ex_packet_out [CDB_WIDTH]
);

  localparam int unsigned PW = $clog2(NUM_FU);
  localparam int unsigned CW = $clog2(CDB_WIDTH + 1);

  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("STARVE_LIMIT must fit a 3-bit saturating counter");
  end

  logic [NUM_FU-1:0] hold_valid_q, hold_valid_d;
  EX_PACKET          hold_pkt_q [NUM_FU];
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0] grant, capture, aged;
  EX_PACKET          slot_pkt [CDB_WIDTH];
  logic [CW-1:0]     n_grant;
  logic [PW-1:0]     idx;

`ifdef CDB_ARB_AGE_EN
  logic [2:0] wait_q [NUM_FU];

  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      aged[i] = hold_valid_q[i] && (wait_q[i] == 3'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (reset || squash || grant[i] || capture[i] || !hold_valid_q[i]) begin
        wait_q[i] <= '0;
      end else if (wait_q[i] != 3'(STARVE_LIMIT)) begin
        wait_q[i] <= wait_q[i] + 3'd1;
      end
    end
  end
`else
  assign aged = '0;
`endif

  // Pass 0 takes starved entries, pass 1 the rest; both scan from rr_ptr.
  // Only pass-1 grants move the pointer.
  always_comb begin
    grant    = '0;
    n_grant  = '0;
    idx      = '0;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
      slot_pkt[k] = '0;
    end
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned j = 0; j < NUM_FU; j++) begin
        idx = PW'((32'(rr_ptr_q) + j) % NUM_FU);
        if (hold_valid_q[idx] && !grant[idx] && (32'(n_grant) < CDB_WIDTH) &&
            ((pass == 1) || aged[idx])) begin
          grant[idx]        = 1'b1;
          slot_pkt[n_grant] = hold_pkt_q[idx];
          n_grant           = n_grant + CW'(1);
          if (pass == 1) begin
            rr_ptr_d = PW'((32'(idx) + 1) % NUM_FU);
          end
        end
      end
    end
  end

  always_comb begin
    fu_stall_out = hold_valid_q & ~grant;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      capture[i] = fu_packet_in[i].valid && !fu_stall_out[i];
    end
    hold_valid_d = (hold_valid_q & ~grant) | capture;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
        ex_packet_out[k] <= '0;
      end
    end else if (squash) begin
      hold_valid_q <= '0;
      for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
        ex_packet_out[k] <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
        ex_packet_out[k] <= slot_pkt[k];
      end
    end
  end

  // Payload needs no reset: hold_valid_q alone qualifies it.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (capture[i]) begin
        hold_pkt_q[i] <= fu_packet_in[i];
      end
    end
  end

endmodule
